piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter. It is the counterpart to the team's SIPO shift register (serial-in, parallel-out, direction-selectable, enable-gated). It accepts a REG_LEN-bit word through a valid/ready load handshake and emits the word one bit per enabled cycle, in the bit order that lets the SIPO reassemble it. It provides a per-bit strobe and a last-bit flag, and supports back-to-back words with no idle cycle.

---
 rtl/piso_serializer_pkg.sv | 13 +
 rtl/piso_serializer.sv | 107 ++++++++++
 tb/tb_piso_serializer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer and its SIPO counterpart.
// The direction encoding must match the SIPO's dir input.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a valid/ready load handshake.
// It emits one bit per enabled cycle and accepts back-to-back words on the final bit.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned REG_LEN = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [REG_LEN-1:0] load_data,
  input  logic               load_dir,
  input  logic               en,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               ser_last,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(REG_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REG_LEN - 1);

  if (REG_LEN < 2) begin : g_bad_reg_len
    $error("piso_serializer: REG_LEN must be >= 2");
  end

  state_e             state_q, state_d;
  logic [REG_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_last_q, ser_last_d;

  logic shift_en_c;
  logic final_bit_c;
  logic accept_c;

  // Handshake: a new word may enter while idle or on the edge that emits the final bit.
  assign shift_en_c  = (state_q == SHIFT) && en;
  assign final_bit_c = shift_en_c && (cnt_q == LAST_CNT);
  assign load_ready  = (state_q == IDLE) || final_bit_c;
  assign accept_c    = load_valid && load_ready;
  assign busy        = (state_q == SHIFT);

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  // Next state: leave SHIFT after the final bit unless a follow-on word is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = SHIFT;
      SHIFT:   if (final_bit_c && !accept_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; an accept overrides the shift of the outgoing word.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;

    if (shift_en_c) begin
      ser_out_d   = (dir_q == DIR_MSB_FIRST) ? shreg_q[REG_LEN-1] : shreg_q[0];
      ser_valid_d = 1'b1;
      ser_last_d  = final_bit_c;
      shreg_d     = (dir_q == DIR_LSB_FIRST) ? {1'b0, shreg_q[REG_LEN-1:1]}
                                             : {shreg_q[REG_LEN-2:0], 1'b0};
      cnt_d       = cnt_q + CNT_W'(1);
    end

    if (accept_c) begin
      shreg_d = load_data;
      dir_d   = load_dir;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed vector table, hand-written
// corner sequences with a SIPO loopback, and randomized traffic against a bit-queue model.
module tb_piso_serializer;

  localparam int unsigned N = 4;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [N-1:0] load_data = '0;
  logic         load_dir = 1'b0;
  logic         en = 1'b0;
  logic         ser_out, ser_valid, ser_last, busy;

  int n_vec = 0;
  int n_err = 0;

  piso_serializer #(.REG_LEN(N)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dir   (load_dir),
    .en         (en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic         rst, lv;
    logic [N-1:0] data;
    logic         dir, en;
    logic         chk_rdy, rdy;
    logic         out, vld, lst, bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, lv, input logic [N-1:0] data, input logic dir, e,
                     input logic chk_rdy, rdy, out, vld, lst, bsy);
    vec_t v;
    v.rst = rst; v.lv = lv; v.data = data; v.dir = dir; v.en = e;
    v.chk_rdy = chk_rdy; v.rdy = rdy;
    v.out = out; v.vld = vld; v.lst = lst; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  logic [N-1:0] sipo;
  logic         bits[8];
  logic         vlds[8];
  logic         lsts[8];
  int           nvalid;

  // Reference model: pending serial bits of the current word, in emission order.
  logic         q[$];
  logic         m_out, m_vld, m_lst, m_rdy, m_acc;

  initial begin
    // ---- Directed table ----
    //   rst lv data     dir en  chk rdy  out vld lst bsy
    add(1, 0, 4'h0,    0, 0,  0,  0,   0,  0,  0,  0);   // reset
    add(0, 1, 4'b1011, 0, 1,  1,  1,   0,  0,  0,  1);   // accept, LSB first
    add(0, 0, 4'h0,    0, 1,  1,  0,   1,  1,  0,  1);
    add(0, 0, 4'h0,    1, 1,  1,  0,   1,  1,  0,  1);   // dir change ignored
    add(0, 0, 4'h0,    0, 1,  1,  0,   0,  1,  0,  1);
    add(0, 0, 4'h0,    0, 1,  1,  1,   1,  1,  1,  0);
    add(0, 0, 4'h0,    0, 1,  1,  1,   1,  0,  0,  0);   // idle, ser_out holds
    add(0, 1, 4'b1011, 1, 0,  1,  1,   1,  0,  0,  1);   // accept with en=0, MSB first
    add(0, 0, 4'h0,    0, 1,  1,  0,   1,  1,  0,  1);
    add(0, 0, 4'h0,    0, 1,  1,  0,   0,  1,  0,  1);
    add(0, 0, 4'h0,    0, 1,  1,  0,   1,  1,  0,  1);
    add(0, 0, 4'h0,    0, 1,  1,  1,   1,  1,  1,  0);
    add(0, 1, 4'b0110, 0, 1,  1,  1,   1,  0,  0,  1);   // stall test word
    add(0, 0, 4'h0,    0, 1,  1,  0,   0,  1,  0,  1);
    add(0, 0, 4'h0,    0, 1,  1,  0,   1,  1,  0,  1);
    add(0, 0, 4'h0,    0, 0,  1,  0,   1,  0,  0,  1);   // stall x3
    add(0, 0, 4'h0,    0, 0,  1,  0,   1,  0,  0,  1);
    add(0, 0, 4'h0,    0, 0,  1,  0,   1,  0,  0,  1);
    add(0, 0, 4'h0,    0, 1,  1,  0,   1,  1,  0,  1);
    add(0, 0, 4'h0,    0, 1,  1,  1,   0,  1,  1,  0);

    #2;
    foreach (tbl[i]) begin
      rst_in = tbl[i].rst; load_valid = tbl[i].lv; load_data = tbl[i].data;
      load_dir = tbl[i].dir; en = tbl[i].en;
      #1;
      if (tbl[i].chk_rdy) chk($sformatf("tbl%0d.load_ready", i), int'(load_ready), int'(tbl[i].rdy));
      tick();
      chk($sformatf("tbl%0d.ser_out", i),   int'(ser_out),   int'(tbl[i].out));
      chk($sformatf("tbl%0d.ser_valid", i), int'(ser_valid), int'(tbl[i].vld));
      chk($sformatf("tbl%0d.ser_last", i),  int'(ser_last),  int'(tbl[i].lst));
      chk($sformatf("tbl%0d.busy", i),      int'(busy),      int'(tbl[i].bsy));
    end
    rst_in = 0; load_valid = 0; en = 1;

    // ---- SIPO loopback, both directions ----
    for (int d = 0; d < 2; d++) begin
      sipo = '0;
      load_valid = 1; load_data = 4'b1011; load_dir = logic'(d);
      tick();
      load_valid = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (ser_valid) sipo = (d == 1) ? {sipo[N-2:0], ser_out} : {ser_out, sipo[N-1:1]};
      end
      chk($sformatf("loopback_dir%0d.last", d), int'(ser_last), 1);
      chk($sformatf("loopback_dir%0d.word", d), int'(sipo), int'(4'b1011));
    end

    // ---- Back-to-back 4'hA then 4'h5 ----
    load_valid = 1; load_data = 4'hA; load_dir = 0; en = 1;
    tick();
    load_data = 4'h5;
    for (int i = 0; i < 8; i++) begin
      tick();
      bits[i] = ser_out; vlds[i] = ser_valid; lsts[i] = ser_last;
      if (i == 3) begin
        chk("b2b.busy_at_word_edge", int'(busy), 1);
        load_valid = 0;
      end
    end
    begin
      logic [7:0] exp_bits;
      exp_bits = 8'b01011010;   // emission order 0,1,0,1,1,0,1,0 (MSB of literal = first bit)
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("b2b.bit%0d", i),   int'(bits[i]), int'(exp_bits[7-i]));
        chk($sformatf("b2b.valid%0d", i), int'(vlds[i]), 1);
        chk($sformatf("b2b.last%0d", i),  int'(lsts[i]), (i == 3 || i == 7) ? 1 : 0);
      end
    end
    chk("b2b.busy_after", int'(busy), 0);

    // ---- Reset mid-word, then a fresh word ----
    load_valid = 1; load_data = 4'hC; load_dir = 0; en = 1;
    tick();
    load_valid = 0;
    tick(); tick();
    rst_in = 1;
    tick();
    rst_in = 0;
    #1;
    chk("rst.ser_out", int'(ser_out), 0);
    chk("rst.ser_valid", int'(ser_valid), 0);
    chk("rst.ser_last", int'(ser_last), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.load_ready", int'(load_ready), 1);
    load_valid = 1; load_data = 4'hF;
    tick();
    load_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst.bit%0d", i), int'(ser_out), 1);
      chk($sformatf("post_rst.valid%0d", i), int'(ser_valid), 1);
      chk($sformatf("post_rst.last%0d", i), int'(ser_last), (i == 3) ? 1 : 0);
    end

    // ---- Dir toggles and load_valid pulses while busy ----
    tick();
    load_valid = 1; load_data = 4'b0011; load_dir = 0; en = 1;
    tick();
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        load_valid = 1; load_data = 4'hF; load_dir = ~load_dir;
        #1;
        chk($sformatf("busy_load.ready%0d", i), int'(load_ready), 0);
      end else begin
        load_valid = 0;
      end
      tick();
      if (ser_valid) nvalid++;
      if (i < 4) chk($sformatf("busy_load.bit%0d", i), int'(ser_out), (i < 2) ? 1 : 0);
    end
    chk("busy_load.valid_count", nvalid, 4);
    chk("busy_load.busy_end", int'(busy), 0);

    // ---- Randomized traffic against the bit-queue model ----
    rst_in = 1; load_valid = 0; en = 0;
    tick();
    q.delete(); m_out = 0; m_vld = 0; m_lst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_in     = ($urandom_range(0, 99) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = N'($urandom);
      load_dir   = ($urandom_range(0, 1) == 1);
      en         = ($urandom_range(0, 3) != 0);
      #1;
      m_rdy = (q.size() == 0) || (en && q.size() == 1);
      chk($sformatf("rnd%0d.load_ready", c), int'(load_ready), int'(m_rdy));
      tick();
      if (rst_in) begin
        q.delete(); m_out = 0; m_vld = 0; m_lst = 0;
      end else begin
        m_acc = load_valid && m_rdy;
        if (q.size() > 0 && en) begin
          m_out = q.pop_front();
          m_vld = 1;
          m_lst = (q.size() == 0);
        end else begin
          m_vld = 0;
          m_lst = 0;
        end
        if (m_acc) begin
          for (int b = 0; b < N; b++)
            q.push_back(load_dir ? load_data[N-1-b] : load_data[b]);
        end
      end
      chk($sformatf("rnd%0d.ser_out", c),   int'(ser_out),   int'(m_out));
      chk($sformatf("rnd%0d.ser_valid", c), int'(ser_valid), int'(m_vld));
      chk($sformatf("rnd%0d.ser_last", c),  int'(ser_last),  int'(m_lst));
      chk($sformatf("rnd%0d.busy", c),      int'(busy),      (q.size() > 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
